// File: rtl/card_shoe.sv
// 52-card shoe: deck build, LFSR Fisher-Yates shuffle, then one card per req with 1-cycle latency.
// No backpressure; refused draws pulse err, and shuffle is ignored while busy.
module card_shoe #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        shuffle,
  input  logic [15:0] seed,
  input  logic        req,
  output logic        valid,
  output logic [3:0]  data,
  output logic [5:0]  card_idx,
  output logic [5:0]  remaining,
  output logic        empty,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, INIT, SHUF, READY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  deck [52];
  logic [5:0]  pos;
  logic [5:0]  ptr;
  logic [15:0] lfsr;
  logic [15:0] lfsr_adv;
  logic [5:0]  j;
  logic [5:0]  rank;
  logic [3:0]  init_val;
  logic        accept;
  logic        swap_en;
  logic        last_swap;
  logic        deal;
  logic        refuse;

  always_comb begin
    lfsr_adv  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    j         = lfsr_adv[5:0];
    swap_en   = (state == SHUF) && (j <= pos);
    last_swap = swap_en && (pos == 6'd1);
    accept    = shuffle && ((state == IDLE) || (state == READY));
    deal      = (state == READY) && req && !shuffle && (remaining != 6'd0);
    refuse    = req && !accept && !deal;
    rank      = pos % 6'd13;
    init_val  = (rank >= 6'd9) ? 4'd10 : (rank[3:0] + 4'd1);
    busy      = (state == INIT) || (state == SHUF);
    empty     = (remaining == 6'd0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shuffle) state_nxt = INIT;
      INIT:    if (pos == 6'd51) state_nxt = SHUF;
      SHUF:    if (last_swap) state_nxt = READY;
      READY:   if (shuffle) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pos       <= 6'd0;
      ptr       <= 6'd0;
      lfsr      <= SEED_DEFAULT;
      remaining <= 6'd0;
      valid     <= 1'b0;
      data      <= 4'd0;
      card_idx  <= 6'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= deal;
      err   <= refuse;
      done  <= last_swap;
      if (accept) begin
        lfsr      <= (seed == 16'd0) ? SEED_DEFAULT : seed;
        pos       <= 6'd0;
        ptr       <= 6'd0;
        remaining <= 6'd0;
      end else begin
        case (state)
          // pos stops at 51 so it enters SHUF already holding i=51
          INIT: if (pos != 6'd51) pos <= pos + 6'd1;
          SHUF: begin
            lfsr <= lfsr_adv;
            if (swap_en) begin
              pos <= pos - 6'd1;
              if (pos == 6'd1) begin
                remaining <= 6'd52;
                ptr       <= 6'd0;
              end
            end
          end
          READY: if (deal) begin
            data      <= deck[ptr];
            card_idx  <= ptr;
            ptr       <= ptr + 6'd1;
            remaining <= remaining - 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Deck storage is intentionally unreset; it is only meaningful after done.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      deck[pos] <= init_val;
    end else if (swap_en) begin
      deck[pos] <= deck[j];
      deck[j]   <= deck[pos];
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: expected draws/errors queued at issue, checked by a monitor.
module tb_card_shoe;

  logic        clk = 1'b0;
  logic        reset;
  logic        shuffle;
  logic [15:0] seed;
  logic        req;
  logic        valid;
  logic [3:0]  data;
  logic [5:0]  card_idx;
  logic [5:0]  remaining;
  logic        empty;
  logic        busy;
  logic        done;
  logic        err;

  card_shoe #(.SEED_DEFAULT(16'hACE1)) dut (
    .clk(clk), .reset(reset), .shuffle(shuffle), .seed(seed), .req(req),
    .valid(valid), .data(data), .card_idx(card_idx), .remaining(remaining),
    .empty(empty), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [3:0] val;
    logic [5:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] got[$];
  logic [3:0] first_run[52];
  logic [3:0] exp_deck[52];
  int         checks = 0;
  int         passed = 0;
  int         ptr_m  = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // Reference deck for a seed, plus the number of shuffle cycles it takes.
  task automatic model_shuffle(input logic [15:0] s, output int n);
    logic [15:0] l;
    logic [3:0]  t;
    int          i;
    int          jj;
    l = (s == 16'd0) ? 16'hACE1 : s;
    for (int p = 0; p < 52; p++) exp_deck[p] = ((p % 13) + 1 > 10) ? 4'd10 : 4'((p % 13) + 1);
    i = 51;
    n = 0;
    while (i >= 1 && n < 20000) begin
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      n++;
      jj = int'(l[5:0]);
      if (jj <= i) begin
        t = exp_deck[i];
        exp_deck[i] = exp_deck[jj];
        exp_deck[jj] = t;
        i--;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Call with shuffle already driven high; pulses req at cycles pa/pb while busy.
  task automatic wait_done(input int pa, input int pb, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      shuffle = 1'b0;
      req = 1'b0;
      if (k == 1) begin
        chk("busy_rise", int'(busy), 1);
        chk("no_valid_on_shuffle", int'(valid), 0);
        chk("no_err_on_shuffle", int'(err), 0);
      end
      if (done) begin
        cyc = k;
        break;
      end
      if (k == pa || k == pb) begin
        req = 1'b1;
        exp_q.push_back('{1'b1, 4'd0, 6'd0});
      end
    end
    req = 1'b0;
    ptr_m = 0;
  endtask

  task automatic deal(input int n);
    for (int k = 0; k < n; k++) begin
      req = 1'b1;
      exp_q.push_back('{1'b0, exp_deck[ptr_m], 6'(ptr_m)});
      ptr_m++;
      tick();
    end
    req = 1'b0;
  endtask

  task automatic deal_err;
    req = 1'b1;
    exp_q.push_back('{1'b1, 4'd0, 6'd0});
    tick();
    req = 1'b0;
  endtask

  // Monitor: every valid/err pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid && err) begin
        chk("valid_and_err_together", 1, 0);
      end else if (valid || err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", int'({valid, err}), 0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            chk("err_pulse", int'(err), 1);
          end else begin
            chk("valid_pulse", int'(valid), 1);
            chk("card_value", int'(data), int'(e.val));
            chk("card_idx", int'(card_idx), int'(e.idx));
          end
        end
        if (valid) got.push_back(data);
      end
    end
  end

  task automatic histogram;
    int hist[11];
    for (int v = 0; v < 11; v++) hist[v] = 0;
    foreach (got[i]) if (got[i] <= 4'd10) hist[got[i]]++;
    for (int v = 1; v <= 9; v++) chk($sformatf("hist_%0d", v), hist[v], 4);
    chk("hist_10", hist[10], 16);
  endtask

  initial begin
    int n;
    int cyc;
    int mism;
    reset = 1'b0; shuffle = 1'b0; req = 1'b0; seed = 16'd0;
    repeat (3) tick();
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_card_idx", int'(card_idx), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b1;

    // Draw before any shuffle is refused.
    deal_err();
    chk("idle_req_empty", int'(empty), 1);
    chk("idle_req_remaining", int'(remaining), 0);

    // Seed 0 falls back to the default seed.
    model_shuffle(16'h0000, n);
    seed = 16'h0000; shuffle = 1'b1;
    wait_done(0, 0, cyc);
    chk("done_latency_seed0", cyc, 53 + n);
    chk("done_min_latency", int'(cyc >= 104), 1);
    chk("ready_remaining", int'(remaining), 52);
    chk("ready_empty", int'(empty), 0);
    tick();
    chk("done_one_cycle", int'(done), 0);
    got.delete();
    deal(52);
    deal_err();
    tick();
    chk("drained_remaining", int'(remaining), 0);
    chk("drained_empty", int'(empty), 1);
    chk("deal_count", got.size(), 52);
    histogram();
    for (int i = 0; i < 52; i++) first_run[i] = (i < got.size()) ? got[i] : 4'd0;

    // Explicit default seed, with refused draws during the shuffle.
    model_shuffle(16'hACE1, n);
    seed = 16'hACE1; shuffle = 1'b1;
    wait_done(5, 60, cyc);
    chk("done_latency_ace1", cyc, 53 + n);
    got.delete();
    deal(52);
    tick();
    mism = 0;
    for (int i = 0; i < 52; i++) if (i >= got.size() || got[i] != first_run[i]) mism++;
    chk("seed0_equals_ace1", mism, 0);

    // Shuffle beats req in READY part-way through a deck.
    model_shuffle(16'h1234, n);
    seed = 16'h1234; shuffle = 1'b1;
    wait_done(0, 0, cyc);
    chk("done_latency_1234", cyc, 53 + n);
    deal(22);
    chk("partial_remaining", int'(remaining), 30);
    model_shuffle(16'h4321, n);
    seed = 16'h4321; shuffle = 1'b1; req = 1'b1;
    wait_done(0, 0, cyc);
    chk("done_latency_4321", cyc, 53 + n);
    chk("reshuffle_remaining", int'(remaining), 52);
    got.delete();
    deal(52);
    tick();
    histogram();

    // Reset 20 cycles into SHUF aborts, then a fresh shuffle completes.
    seed = 16'h5555; shuffle = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      tick();
      shuffle = 1'b0;
    end
    chk("in_shuf_busy", int'(busy), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_remaining", int'(remaining), 0);
    chk("abort_empty", int'(empty), 1);
    chk("abort_done", int'(done), 0);
    deal_err();
    model_shuffle(16'h5555, n);
    seed = 16'h5555; shuffle = 1'b1;
    wait_done(0, 0, cyc);
    chk("done_latency_after_abort", cyc, 53 + n);
    chk("after_abort_remaining", int'(remaining), 52);
    deal(52);
    tick();
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
